// File: rtl/noc_credit_valrdy_bridge_pkg.sv
// Shared constants and helpers for the credit <-> val/rdy NoC bridge.
// Optional flit counters are built when NOC_BRIDGE_PERF_CNT_EN is defined.
package noc_credit_valrdy_bridge_pkg;

  localparam int NOC_BRIDGE_PERF_W = 32;

  localparam int NOC_BRIDGE_CH_NOC1 = 0;
  localparam int NOC_BRIDGE_CH_NOC2 = 1;
  localparam int NOC_BRIDGE_CH_NOC3 = 2;

  localparam int NOC_BRIDGE_NUM_CH     = 3;
  localparam int NOC_BRIDGE_DATA_W     = 64;
  localparam int NOC_BRIDGE_FIFO_DEPTH = 4;
  localparam int NOC_BRIDGE_CREDITS    = 4;

  typedef logic [NOC_BRIDGE_PERF_W-1:0] perf_cnt_t;

  function automatic perf_cnt_t sat_inc(
    input perf_cnt_t v
  );
    return (v == '1) ? v : v + perf_cnt_t'(1);
  endfunction

endpackage

// File: rtl/noc_credit_valrdy_bridge_if.sv
// Bundled credit-side and val/rdy-side signals of the NoC bridge.
// slave = bridge side, master = NoC / agent side.
interface noc_credit_valrdy_bridge_if
  import noc_credit_valrdy_bridge_pkg::*;
#(
  parameter int NUM_CH = NOC_BRIDGE_NUM_CH,
  parameter int DATA_W = NOC_BRIDGE_DATA_W
) ();

  logic [NUM_CH-1:0]        cr_in_valid;
  logic [NUM_CH*DATA_W-1:0] cr_in_data;
  logic [NUM_CH-1:0]        cr_in_yummy;
  logic [NUM_CH-1:0]        vr_out_valid;
  logic [NUM_CH*DATA_W-1:0] vr_out_data;
  logic [NUM_CH-1:0]        vr_out_ready;

  logic [NUM_CH-1:0]        vr_in_valid;
  logic [NUM_CH*DATA_W-1:0] vr_in_data;
  logic [NUM_CH-1:0]        vr_in_ready;
  logic [NUM_CH-1:0]        cr_out_valid;
  logic [NUM_CH*DATA_W-1:0] cr_out_data;
  logic [NUM_CH-1:0]        cr_out_yummy;

  logic [NUM_CH-1:0]        ovf_err;
  logic [NUM_CH-1:0]        cred_err;

  logic [NUM_CH*NOC_BRIDGE_PERF_W-1:0] perf_in_cnt;
  logic [NUM_CH*NOC_BRIDGE_PERF_W-1:0] perf_out_cnt;

  modport slave (
    input  cr_in_valid,
    input  cr_in_data,
    output cr_in_yummy,
    output vr_out_valid,
    output vr_out_data,
    input  vr_out_ready,
    input  vr_in_valid,
    input  vr_in_data,
    output vr_in_ready,
    output cr_out_valid,
    output cr_out_data,
    input  cr_out_yummy,
    output ovf_err,
    output cred_err,
    output perf_in_cnt,
    output perf_out_cnt
  );

  modport master (
    output cr_in_valid,
    output cr_in_data,
    input  cr_in_yummy,
    input  vr_out_valid,
    input  vr_out_data,
    output vr_out_ready,
    output vr_in_valid,
    output vr_in_data,
    input  vr_in_ready,
    input  cr_out_valid,
    input  cr_out_data,
    output cr_out_yummy,
    input  ovf_err,
    input  cred_err,
    input  perf_in_cnt,
    input  perf_out_cnt
  );

endinterface

// File: rtl/noc_credit_valrdy_bridge_fifo.sv
// Show-ahead FIFO for one ingress channel of the NoC bridge.
// Pointers carry an extra MSB to split full from empty.
module noc_credit_valrdy_bridge_fifo #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A push into a full FIFO is only taken when the head leaves this cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign dout = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/noc_credit_valrdy_bridge.sv
// Multi-channel credit <-> val/rdy NoC bridge with sticky error flags.
// Define NOC_BRIDGE_PERF_CNT_EN to build per-channel flit counters.
module noc_credit_valrdy_bridge
  import noc_credit_valrdy_bridge_pkg::*;
#(
  parameter int NUM_CH     = NOC_BRIDGE_NUM_CH,
  parameter int DATA_W     = NOC_BRIDGE_DATA_W,
  parameter int FIFO_DEPTH = NOC_BRIDGE_FIFO_DEPTH,
  parameter int CREDITS    = NOC_BRIDGE_CREDITS
) (
  input  logic                        clk,
  input  logic                        reset,
  noc_credit_valrdy_bridge_if.slave   bus
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam int PW = NOC_BRIDGE_PERF_W;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch

    logic              full;
    logic              empty;
    logic              pop;
    logic              push;
    logic [DATA_W-1:0] head;
    logic              yummy_q;
    logic              ovf_q;

    logic              hs;
    logic              yum;
    logic [CW-1:0]     cnt_q;
    logic              cred_q;
    logic              ov_q;
    logic [DATA_W-1:0] od_q;

    assign push = bus.cr_in_valid[c];
    assign pop  = !empty && bus.vr_out_ready[c];

    noc_credit_valrdy_bridge_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (bus.cr_in_data[c*DATA_W +: DATA_W]),
      .dout  (head),
      .full  (full),
      .empty (empty)
    );

    always_ff @(posedge clk) begin
      if (reset) begin
        yummy_q <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        yummy_q <= pop;
        if (full && push && !pop) ovf_q <= 1'b1;
      end
    end

    assign hs  = bus.vr_in_valid[c] && (cnt_q != '0);
    assign yum = bus.cr_out_yummy[c];

    // A yummy that would push the count past CREDITS is flagged, not counted.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q  <= CRED_MAX;
        cred_q <= 1'b0;
        ov_q   <= 1'b0;
        od_q   <= '0;
      end else begin
        ov_q <= hs;
        if (hs) od_q <= bus.vr_in_data[c*DATA_W +: DATA_W];
        if (yum && !hs) begin
          if (cnt_q == CRED_MAX) cred_q <= 1'b1;
          else cnt_q <= cnt_q + CW'(1);
        end else if (hs && !yum) begin
          cnt_q <= cnt_q - CW'(1);
        end
      end
    end

    assign bus.cr_in_yummy[c]                 = yummy_q;
    assign bus.vr_out_valid[c]                = !empty;
    assign bus.vr_out_data[c*DATA_W +: DATA_W] = head;
    assign bus.ovf_err[c]                     = ovf_q;
    assign bus.vr_in_ready[c]                 = (cnt_q != '0);
    assign bus.cr_out_valid[c]                = ov_q;
    assign bus.cr_out_data[c*DATA_W +: DATA_W] = od_q;
    assign bus.cred_err[c]                    = cred_q;

`ifdef NOC_BRIDGE_PERF_CNT_EN
    perf_cnt_t pin_q;
    perf_cnt_t pout_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        pin_q  <= '0;
        pout_q <= '0;
      end else begin
        if (pop) pin_q <= sat_inc(pin_q);
        if (hs)  pout_q <= sat_inc(pout_q);
      end
    end

    assign bus.perf_in_cnt[c*PW +: PW]  = pin_q;
    assign bus.perf_out_cnt[c*PW +: PW] = pout_q;
`else
    assign bus.perf_in_cnt[c*PW +: PW]  = '0;
    assign bus.perf_out_cnt[c*PW +: PW] = '0;
`endif

  end

endmodule
